// File: rtl/instr_buffer.sv
// instr_buffer: circular decoupling queue between fetch and decode.
// Accepts up to FETCH_WIDTH compacted instructions per cycle and presents
// up to DECODE_WIDTH of the oldest entries to decode. A flush empties it.
module instr_buffer #(
  parameter int SIZE         = 32,
  parameter int FETCH_WIDTH  = 4,
  parameter int DECODE_WIDTH = 2,
  parameter int ADDR_WIDTH   = 32,
  parameter int INSTR_WIDTH  = 32
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  flush_i,
  input  logic [FETCH_WIDTH-1:0]                fetch_valid_i,
  input  logic [FETCH_WIDTH*ADDR_WIDTH-1:0]     fetch_pc_i,
  input  logic [FETCH_WIDTH*INSTR_WIDTH-1:0]    fetch_instr_i,
  input  logic [FETCH_WIDTH-1:0]                fetch_pred_taken_i,
  output logic                                  fetch_ready_o,
  output logic [DECODE_WIDTH-1:0]               dec_valid_o,
  output logic [DECODE_WIDTH*ADDR_WIDTH-1:0]    dec_pc_o,
  output logic [DECODE_WIDTH*INSTR_WIDTH-1:0]   dec_instr_o,
  output logic [DECODE_WIDTH-1:0]               dec_pred_taken_o,
  input  logic [DECODE_WIDTH-1:0]               dec_ready_i,
  output logic [$clog2(SIZE):0]                 count_o
);

  localparam int PTR_W = $clog2(SIZE);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0]  pc_mem    [SIZE];
  logic [INSTR_WIDTH-1:0] instr_mem [SIZE];
  logic [SIZE-1:0]        pred_mem;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic             wr_en;
  logic [CNT_W-1:0] n_w;
  logic [CNT_W-1:0] n_w_eff;
  logic [CNT_W-1:0] n_r;
  logic [PTR_W-1:0] wr_idx [FETCH_WIDTH];
  logic [PTR_W-1:0] rd_idx;
  logic             rd_stop;

  // Room for a whole fetch group, judged on the registered count only
  assign fetch_ready_o = (CNT_W'(SIZE) - count) >= CNT_W'(FETCH_WIDTH);
  assign wr_en         = fetch_ready_o && !flush_i;
  assign n_w_eff       = wr_en ? n_w : '0;
  assign count_o       = count;

  // Compaction: each valid slot lands at tail plus the number of valid slots below it
  always_comb begin
    n_w = '0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      wr_idx[i] = tail + n_w[PTR_W-1:0];
      if (fetch_valid_i[i]) begin
        n_w = n_w + CNT_W'(1);
      end
    end
  end

  // Entry storage; never cleared, occupancy is tracked by the pointers alone
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
        if (fetch_valid_i[i]) begin
          pc_mem[wr_idx[i]]    <= fetch_pc_i[i*ADDR_WIDTH +: ADDR_WIDTH];
          instr_mem[wr_idx[i]] <= fetch_instr_i[i*INSTR_WIDTH +: INSTR_WIDTH];
          pred_mem[wr_idx[i]]  <= fetch_pred_taken_i[i];
        end
      end
    end
  end

  // Decode view of the head entries, zero-masked when invalid; counts the leading accepted slots
  always_comb begin
    n_r              = '0;
    rd_stop          = 1'b0;
    rd_idx           = '0;
    dec_valid_o      = '0;
    dec_pc_o         = '0;
    dec_instr_o      = '0;
    dec_pred_taken_o = '0;
    for (int unsigned k = 0; k < DECODE_WIDTH; k++) begin
      rd_idx = head + PTR_W'(k);
      if ((count > CNT_W'(k)) && !flush_i) begin
        dec_valid_o[k]                             = 1'b1;
        dec_pc_o[k*ADDR_WIDTH +: ADDR_WIDTH]       = pc_mem[rd_idx];
        dec_instr_o[k*INSTR_WIDTH +: INSTR_WIDTH]  = instr_mem[rd_idx];
        dec_pred_taken_o[k]                        = pred_mem[rd_idx];
        if (!rd_stop && dec_ready_i[k]) begin
          n_r = n_r + CNT_W'(1);
        end else begin
          rd_stop = 1'b1;
        end
      end else begin
        rd_stop = 1'b1;
      end
    end
  end

  // Pointer and occupancy update; flush outranks any read or write in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + n_r[PTR_W-1:0];
      tail  <= tail + n_w_eff[PTR_W-1:0];
      count <= count + n_w_eff - n_r;
    end
  end

endmodule

// File: tb/tb_instr_buffer.sv
// Self-checking bench for instr_buffer against a queue-based reference model.
module tb_instr_buffer;

  localparam int SIZE = 32;
  localparam int FW   = 4;
  localparam int DW   = 2;
  localparam int AW   = 32;
  localparam int IW   = 32;
  localparam int CW   = 6;

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
    logic          pred;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              flush_i = 1'b0;
  logic [FW-1:0]     fetch_valid_i = '0;
  logic [FW*AW-1:0]  fetch_pc_i = '0;
  logic [FW*IW-1:0]  fetch_instr_i = '0;
  logic [FW-1:0]     fetch_pred_taken_i = '0;
  logic              fetch_ready_o;
  logic [DW-1:0]     dec_valid_o;
  logic [DW*AW-1:0]  dec_pc_o;
  logic [DW*IW-1:0]  dec_instr_o;
  logic [DW-1:0]     dec_pred_taken_o;
  logic [DW-1:0]     dec_ready_i = '0;
  logic [CW-1:0]     count_o;

  ent_t q[$];
  int   wr_total = 0;
  int   errors = 0;
  int   checks = 0;

  instr_buffer #(
    .SIZE         (SIZE),
    .FETCH_WIDTH  (FW),
    .DECODE_WIDTH (DW),
    .ADDR_WIDTH   (AW),
    .INSTR_WIDTH  (IW)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .flush_i            (flush_i),
    .fetch_valid_i      (fetch_valid_i),
    .fetch_pc_i         (fetch_pc_i),
    .fetch_instr_i      (fetch_instr_i),
    .fetch_pred_taken_i (fetch_pred_taken_i),
    .fetch_ready_o      (fetch_ready_o),
    .dec_valid_o        (dec_valid_o),
    .dec_pc_o           (dec_pc_o),
    .dec_instr_o        (dec_instr_o),
    .dec_pred_taken_o   (dec_pred_taken_o),
    .dec_ready_i        (dec_ready_i),
    .count_o            (count_o)
  );

  always #5 clk = ~clk;

  // Expected {count, fetch_ready, dec_valid} from the queue contents
  function automatic logic [CW+DW:0] m_status();
    logic [DW-1:0] v;
    v = '0;
    for (int k = 0; k < DW; k++) v[k] = (q.size() > k) && !flush_i;
    return {CW'(q.size()), (SIZE - q.size()) >= FW, v};
  endfunction

  // Expected {pc, instr, pred} of the head slots, zero where invalid
  function automatic logic [DW*(AW+IW+1)-1:0] m_data();
    logic [DW*AW-1:0] p;
    logic [DW*IW-1:0] n;
    logic [DW-1:0]    r;
    p = '0; n = '0; r = '0;
    for (int k = 0; k < DW; k++) begin
      if (q.size() > k && !flush_i) begin
        p[k*AW +: AW] = q[k].pc;
        n[k*IW +: IW] = q[k].instr;
        r[k]          = q[k].pred;
      end
    end
    return {p, n, r};
  endfunction

  // Apply one cycle of inputs; slot PCs are base+4*i, payloads random
  task automatic drive(input logic [FW-1:0] v, input logic [DW-1:0] r,
                       input logic f, input logic [AW-1:0] base);
    fetch_valid_i = v;
    dec_ready_i   = r;
    flush_i       = f;
    for (int i = 0; i < FW; i++) begin
      fetch_pc_i[i*AW +: AW]    = base + AW'(4 * i);
      fetch_instr_i[i*IW +: IW] = $urandom;
      fetch_pred_taken_i[i]     = 1'($urandom_range(0, 1));
    end
    #1;
  endtask

  // Clock edge plus the reference model's view of what that edge does
  task automatic tick();
    int nr;
    bit rdy;
    ent_t e;
    @(posedge clk);
    if (flush_i) begin
      q.delete();
      wr_total = 0;
    end else begin
      rdy = (SIZE - q.size()) >= FW;
      nr  = 0;
      for (int k = 0; k < DW; k++)
        if (nr == k && k < q.size() && dec_ready_i[k]) nr++;
      repeat (nr) void'(q.pop_front());
      if (rdy) begin
        for (int i = 0; i < FW; i++) begin
          if (fetch_valid_i[i]) begin
            e.pc    = fetch_pc_i[i*AW +: AW];
            e.instr = fetch_instr_i[i*IW +: IW];
            e.pred  = fetch_pred_taken_i[i];
            q.push_back(e);
            wr_total++;
          end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({count_o, fetch_ready_o, dec_valid_o} !== {6'd0, 1'b1, 2'b00}) begin
      errors++;
      $display("FAIL reset_status got=%h exp=%h", {count_o, fetch_ready_o, dec_valid_o}, {6'd0, 1'b1, 2'b00});
    end
    checks++;
    if ({dec_pc_o, dec_instr_o, dec_pred_taken_o} !== '0) begin
      errors++;
      $display("FAIL reset_data got=%h exp=0", {dec_pc_o, dec_instr_o, dec_pred_taken_o});
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int g = 0; g < 9; g++) begin
      drive(4'b1111, 2'b00, 1'b0, 32'h1c00_0000 + 32'(16 * g));
      checks++;
      if ({count_o, fetch_ready_o, dec_valid_o} !== m_status()) begin
        errors++;
        $display("FAIL fill_status g=%0d got=%h exp=%h", g, {count_o, fetch_ready_o, dec_valid_o}, m_status());
      end
      checks++;
      if ({dec_pc_o, dec_instr_o, dec_pred_taken_o} !== m_data()) begin
        errors++;
        $display("FAIL fill_data g=%0d got=%h exp=%h", g, {dec_pc_o, dec_instr_o, dec_pred_taken_o}, m_data());
      end
      tick();
      if (g == 6) begin
        checks++;
        if ({count_o, fetch_ready_o} !== {6'd28, 1'b1}) begin
          errors++;
          $display("FAIL fill_28 got count=%0d ready=%b exp count=28 ready=1", count_o, fetch_ready_o);
        end
      end
      if (g >= 7) begin
        checks++;
        if ({count_o, fetch_ready_o} !== {6'd32, 1'b0}) begin
          errors++;
          $display("FAIL fill_full g=%0d got count=%0d ready=%b exp count=32 ready=0", g, count_o, fetch_ready_o);
        end
      end
    end
  endtask

  task automatic test_drain();
    for (int c = 0; c < 16; c++) begin
      drive(4'b0000, 2'b11, 1'b0, 32'h0);
      checks++;
      if ({count_o, fetch_ready_o, dec_valid_o} !== m_status()) begin
        errors++;
        $display("FAIL drain_status c=%0d got=%h exp=%h", c, {count_o, fetch_ready_o, dec_valid_o}, m_status());
      end
      checks++;
      if ({dec_pc_o, dec_instr_o, dec_pred_taken_o} !== m_data()) begin
        errors++;
        $display("FAIL drain_data c=%0d got=%h exp=%h", c, {dec_pc_o, dec_instr_o, dec_pred_taken_o}, m_data());
      end
      if (c == 2) begin
        checks++;
        if (fetch_ready_o !== 1'b1) begin
          errors++;
          $display("FAIL drain_ready_return got=%b exp=1", fetch_ready_o);
        end
      end
      tick();
    end
    drive(4'b0000, 2'b00, 1'b0, 32'h0);
    checks++;
    if ({count_o, dec_valid_o} !== {6'd0, 2'b00}) begin
      errors++;
      $display("FAIL drain_empty got count=%0d valid=%b exp count=0 valid=00", count_o, dec_valid_o);
    end
  endtask

  task automatic test_compaction();
    logic [AW-1:0] base;
    base = 32'h2000_0000;
    drive(4'b1010, 2'b00, 1'b0, base);
    tick();
    drive(4'b0000, 2'b01, 1'b0, 32'h0);
    checks++;
    if ({count_o, dec_pc_o} !== {6'd2, base + 32'd12, base + 32'd4}) begin
      errors++;
      $display("FAIL compact_slots got count=%0d pc=%h exp count=2 pc=%h_%h", count_o, dec_pc_o, base + 32'd12, base + 32'd4);
    end
    checks++;
    if ({dec_pc_o, dec_instr_o, dec_pred_taken_o} !== m_data()) begin
      errors++;
      $display("FAIL compact_data got=%h exp=%h", {dec_pc_o, dec_instr_o, dec_pred_taken_o}, m_data());
    end
    tick();
    drive(4'b0000, 2'b01, 1'b0, 32'h0);
    checks++;
    if ({count_o, dec_valid_o, dec_pc_o[AW-1:0]} !== {6'd1, 2'b01, base + 32'd12}) begin
      errors++;
      $display("FAIL partial_read got count=%0d valid=%b pc0=%h exp count=1 valid=01 pc0=%h", count_o, dec_valid_o, dec_pc_o[AW-1:0], base + 32'd12);
    end
    tick();
  endtask

  task automatic test_wrap();
    int need;
    int guard;
    logic [FW-1:0] v;
    need = (30 - (wr_total % SIZE) + SIZE) % SIZE;
    while (need > 0) begin
      v = (need >= FW) ? 4'b1111 : 4'(4'b1111 >> (FW - need));
      drive(v, 2'b11, 1'b0, 32'h3000_0000 + 32'(wr_total * 4));
      tick();
      need = (30 - (wr_total % SIZE) + SIZE) % SIZE;
    end
    guard = 0;
    while (q.size() > 0 && guard < 40) begin
      drive(4'b0000, 2'b11, 1'b0, 32'h0);
      tick();
      guard++;
    end
    for (int c = 0; c < 4; c++) begin
      drive(4'b1111, 2'b11, 1'b0, 32'h4000_0000 + 32'(16 * c));
      checks++;
      if ({count_o, fetch_ready_o, dec_valid_o} !== m_status()) begin
        errors++;
        $display("FAIL wrap_status c=%0d got=%h exp=%h", c, {count_o, fetch_ready_o, dec_valid_o}, m_status());
      end
      checks++;
      if ({dec_pc_o, dec_instr_o, dec_pred_taken_o} !== m_data()) begin
        errors++;
        $display("FAIL wrap_data c=%0d got=%h exp=%h", c, {dec_pc_o, dec_instr_o, dec_pred_taken_o}, m_data());
      end
      tick();
      checks++;
      if (count_o !== 6'(4 + 2 * c)) begin
        errors++;
        $display("FAIL wrap_count c=%0d got=%0d exp=%0d", c, count_o, 4 + 2 * c);
      end
    end
    guard = 0;
    while (q.size() > 0 && guard < 40) begin
      drive(4'b0000, 2'b11, 1'b0, 32'h0);
      checks++;
      if ({dec_pc_o, dec_instr_o, dec_pred_taken_o} !== m_data()) begin
        errors++;
        $display("FAIL wrap_drain got=%h exp=%h", {dec_pc_o, dec_instr_o, dec_pred_taken_o}, m_data());
      end
      tick();
      guard++;
    end
  endtask

  task automatic test_flush();
    logic [AW-1:0] fresh;
    drive(4'b0000, 2'b00, 1'b1, 32'h0);
    tick();
    drive(4'b1111, 2'b00, 1'b0, 32'h5000_0000);
    tick();
    drive(4'b1111, 2'b00, 1'b0, 32'h5000_0010);
    tick();
    drive(4'b0011, 2'b00, 1'b0, 32'h5000_0020);
    tick();
    checks++;
    if (count_o !== 6'd10) begin
      errors++;
      $display("FAIL flush_setup got count=%0d exp=10", count_o);
    end
    drive(4'b1111, 2'b11, 1'b1, 32'h5000_0100);
    checks++;
    if (dec_valid_o !== 2'b00) begin
      errors++;
      $display("FAIL flush_valid got=%b exp=00", dec_valid_o);
    end
    tick();
    drive(4'b0000, 2'b00, 1'b0, 32'h0);
    checks++;
    if ({count_o, fetch_ready_o, dec_valid_o} !== {6'd0, 1'b1, 2'b00}) begin
      errors++;
      $display("FAIL flush_after got=%h exp=%h", {count_o, fetch_ready_o, dec_valid_o}, {6'd0, 1'b1, 2'b00});
    end
    fresh = 32'h6000_0000;
    drive(4'b0001, 2'b00, 1'b0, fresh);
    tick();
    drive(4'b0000, 2'b00, 1'b0, 32'h0);
    checks++;
    if ({count_o, dec_valid_o, dec_pc_o[AW-1:0]} !== {6'd1, 2'b01, fresh}) begin
      errors++;
      $display("FAIL flush_fresh got count=%0d valid=%b pc0=%h exp count=1 valid=01 pc0=%h", count_o, dec_valid_o, dec_pc_o[AW-1:0], fresh);
    end
    drive(4'b0000, 2'b00, 1'b1, 32'h0);
    tick();
  endtask

  task automatic test_random();
    logic [FW-1:0] v;
    logic [DW-1:0] r;
    logic          f;
    for (int c = 0; c < 400; c++) begin
      v = 4'($urandom_range(0, 15));
      if ((c / 50) % 2 == 0)
        r = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      else
        r = 2'($urandom_range(0, 3));
      f = ($urandom_range(0, 40) == 0);
      drive(v, r, f, $urandom & 32'hffff_fffc);
      checks++;
      if ({count_o, fetch_ready_o, dec_valid_o} !== m_status()) begin
        errors++;
        $display("FAIL rand_status c=%0d got=%h exp=%h", c, {count_o, fetch_ready_o, dec_valid_o}, m_status());
      end
      checks++;
      if ({dec_pc_o, dec_instr_o, dec_pred_taken_o} !== m_data()) begin
        errors++;
        $display("FAIL rand_data c=%0d got=%h exp=%h", c, {dec_pc_o, dec_instr_o, dec_pred_taken_o}, m_data());
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] fresh;
    drive(4'b0000, 2'b00, 1'b1, 32'h0);
    tick();
    for (int g = 0; g < 4; g++) begin
      drive(4'b1111, 2'b00, 1'b0, 32'h7000_0000 + 32'(16 * g));
      tick();
    end
    drive(4'b0001, 2'b00, 1'b0, 32'h7000_0100);
    tick();
    drive(4'b1111, 2'b00, 1'b0, 32'h7000_0200);
    checks++;
    if (count_o !== 6'd17) begin
      errors++;
      $display("FAIL rstmid_setup got count=%0d exp=17", count_o);
    end
    #1 rst_n = 1'b0;
    #1;
    q.delete();
    wr_total = 0;
    checks++;
    if ({count_o, fetch_ready_o, dec_valid_o} !== {6'd0, 1'b1, 2'b00}) begin
      errors++;
      $display("FAIL rstmid_status got=%h exp=%h", {count_o, fetch_ready_o, dec_valid_o}, {6'd0, 1'b1, 2'b00});
    end
    checks++;
    if ({dec_pc_o, dec_instr_o, dec_pred_taken_o} !== '0) begin
      errors++;
      $display("FAIL rstmid_data got=%h exp=0", {dec_pc_o, dec_instr_o, dec_pred_taken_o});
    end
    @(negedge clk) rst_n = 1'b1;
    fresh = 32'h8000_0000;
    drive(4'b0001, 2'b00, 1'b0, fresh);
    tick();
    drive(4'b0000, 2'b00, 1'b0, 32'h0);
    checks++;
    if ({count_o, dec_valid_o, dec_pc_o[AW-1:0]} !== {6'd1, 2'b01, fresh}) begin
      errors++;
      $display("FAIL rstmid_fresh got count=%0d valid=%b pc0=%h exp count=1 valid=01 pc0=%h", count_o, dec_valid_o, dec_pc_o[AW-1:0], fresh);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_compaction();
    test_wrap();
    test_flush();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
